serializer_buf: RTL and testbench

Parallel-to-serial converter that produces the MSB-first bit stream (`ser_data_o`/`ser_data_val_o`) consumed by the lab deserializer stage. It accepts words over a valid/ready handshake and transmits a programmable number of leading bits per word. A one-word holding buffer lets the next word be accepted while the current one is shifting. Back-to-back words are emitted with no idle cycle between them.

---
 rtl/serializer_buf.sv | 140 ++++++++++++++
 tb/tb_serializer_buf.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serializer_buf.sv
// MSB-first parallel-to-serial converter with a one-word holding buffer.
// Words of length 1 or 2 are accepted and discarded. Back-to-back words stream with no idle cycle.
module serializer_buf #(
    parameter int DATA_W = 16,
    parameter int MOD_W  = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              srst_n_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W-1:0]  data_mod_i,
    input  logic              data_val_i,
    output logic              data_rdy_o,
    output logic              ser_data_o,
    output logic              ser_data_val_o,
    output logic              busy_o
);

    localparam int CNT_W = MOD_W + 1;

    typedef enum logic {
        IDLE_S  = 1'b0,
        SHIFT_S = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   hold_word_q, hold_word_d;
    logic [CNT_W-1:0]    hold_len_q, hold_len_d;
    logic                hold_vld_q, hold_vld_d;
    logic                ser_q, ser_d;
    logic                ser_val_q, ser_val_d;

    logic [CNT_W-1:0]    len_s;
    logic                take_s;
    logic                last_s;

    // Effective length, legality of the offered word, and last-bit detection
    always_comb begin
        if (data_mod_i == '0) begin
            len_s = CNT_W'(DATA_W);
        end else begin
            len_s = {1'b0, data_mod_i};
        end
        take_s = data_val_i && !hold_vld_q && (len_s >= CNT_W'(3));
        last_s = (state_q == SHIFT_S) && (cnt_q == CNT_W'(1));
    end

    // Shifter FSM next state, hold buffer management and output register inputs
    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        cnt_d       = cnt_q;
        hold_word_d = hold_word_q;
        hold_len_d  = hold_len_q;
        hold_vld_d  = hold_vld_q;
        ser_d       = ser_q;
        ser_val_d   = ser_val_q;
        case (state_q)
            IDLE_S: begin
                // From idle the MSB goes straight to the output so it appears one cycle after acceptance
                ser_val_d = 1'b0;
                if (hold_vld_q) begin
                    ser_d      = hold_word_q[DATA_W-1];
                    ser_val_d  = 1'b1;
                    word_d     = hold_word_q << 1;
                    cnt_d      = hold_len_q - CNT_W'(1);
                    hold_vld_d = 1'b0;
                    state_d    = SHIFT_S;
                end else if (take_s) begin
                    ser_d     = data_i[DATA_W-1];
                    ser_val_d = 1'b1;
                    word_d    = data_i << 1;
                    cnt_d     = len_s - CNT_W'(1);
                    state_d   = SHIFT_S;
                end else begin
                    state_d = IDLE_S;
                end
            end
            SHIFT_S: begin
                ser_d     = word_q[DATA_W-1];
                ser_val_d = 1'b1;
                word_d    = word_q << 1;
                cnt_d     = cnt_q - CNT_W'(1);
                if (last_s) begin
                    if (hold_vld_q) begin
                        word_d     = hold_word_q;
                        cnt_d      = hold_len_q;
                        hold_vld_d = 1'b0;
                    end else if (take_s) begin
                        word_d = data_i;
                        cnt_d  = len_s;
                    end else begin
                        state_d = IDLE_S;
                    end
                end else if (take_s) begin
                    hold_word_d = data_i;
                    hold_len_d  = len_s;
                    hold_vld_d  = 1'b1;
                end else begin
                    hold_vld_d = hold_vld_q;
                end
            end
            default: begin
                state_d    = IDLE_S;
                ser_val_d  = 1'b0;
                hold_vld_d = 1'b0;
            end
        endcase
    end

    // State and data registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state_q     <= IDLE_S;
            word_q      <= '0;
            cnt_q       <= '0;
            hold_word_q <= '0;
            hold_len_q  <= '0;
            hold_vld_q  <= 1'b0;
            ser_q       <= 1'b0;
            ser_val_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            cnt_q       <= cnt_d;
            hold_word_q <= hold_word_d;
            hold_len_q  <= hold_len_d;
            hold_vld_q  <= hold_vld_d;
            ser_q       <= ser_d;
            ser_val_q   <= ser_val_d;
        end
    end

    assign data_rdy_o     = !hold_vld_q;
    assign ser_data_o     = ser_q;
    assign ser_data_val_o = ser_val_q;
    assign busy_o         = (state_q == SHIFT_S) || hold_vld_q;

endmodule

// File: tb/tb_serializer_buf.sv
// Directed bench for serializer_buf: a cycle-indexed schedule of expected serial bits
// is checked every cycle, plus literal expectations for each scenario.
module tb_serializer_buf;

    logic        clk_i = 1'b0;
    logic        srst_n_i;
    logic [15:0] data_i;
    logic [3:0]  data_mod_i;
    logic        data_val_i;
    logic        data_rdy_o;
    logic        ser_data_o;
    logic        ser_data_val_o;
    logic        busy_o;

    serializer_buf #(.DATA_W(16)) dut (
        .clk_i          (clk_i),
        .srst_n_i       (srst_n_i),
        .data_i         (data_i),
        .data_mod_i     (data_mod_i),
        .data_val_i     (data_val_i),
        .data_rdy_o     (data_rdy_o),
        .ser_data_o     (ser_data_o),
        .ser_data_val_o (ser_data_val_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    localparam int NCYC = 4096;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Expected-output schedule: ev/eb give valid and bit for each cycle index
    bit ev [0:NCYC-1];
    bit eb [0:NCYC-1];
    int lstart   = 0;
    int lend     = 0;
    bit model_on = 1'b0;

    // Capture of what the DUT actually emitted, cleared per scenario
    logic [63:0] cap_w;
    int          cap_n;
    int          cap_run;
    int          cap_maxrun;
    bit          busy_seen;
    bit          rdy_low_seen;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cap_clear();
        cap_w        = '0;
        cap_n        = 0;
        cap_run      = 0;
        cap_maxrun   = 0;
        busy_seen    = 1'b0;
        rdy_low_seen = 1'b0;
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Per-cycle compare against the schedule, then advance the schedule with this cycle's inputs
    always @(negedge clk_i) begin
        bit exp_rdy;
        int len;
        int start;
        exp_rdy = !(cyc + 2 <= lstart);
        if (model_on) begin
            chk("ser_data_val_o", 64'(ser_data_val_o), 64'(ev[cyc]));
            if (ev[cyc]) chk("ser_data_o", 64'(ser_data_o), 64'(eb[cyc]));
            chk("data_rdy_o", 64'(data_rdy_o), 64'(exp_rdy));
            chk("busy_o", 64'(busy_o), 64'(cyc < lend));
        end
        if (ser_data_val_o === 1'b1) begin
            cap_w = {cap_w[62:0], ser_data_o};
            cap_n++;
            cap_run++;
            if (cap_run > cap_maxrun) cap_maxrun = cap_run;
        end else begin
            cap_run = 0;
        end
        if (busy_o === 1'b1) busy_seen = 1'b1;
        if (data_rdy_o === 1'b0) rdy_low_seen = 1'b1;

        if (srst_n_i !== 1'b1) begin
            for (int i = cyc + 1; i < NCYC; i++) begin
                ev[i] = 1'b0;
                eb[i] = 1'b0;
            end
            lstart   = 0;
            lend     = cyc;
            model_on = 1'b1;
        end else if (data_val_i && exp_rdy) begin
            len = (data_mod_i == 4'd0) ? 16 : int'(data_mod_i);
            if (len >= 3) begin
                start = (cyc + 1 > lend + 1) ? cyc + 1 : lend + 1;
                for (int i = 0; i < len; i++) begin
                    ev[start + i] = 1'b1;
                    eb[start + i] = data_i[15 - i];
                end
                lstart = start;
                lend   = start + len - 1;
            end
        end
    end

    task automatic send(input logic [15:0] d, input logic [3:0] m);
        bit done;
        done       = 1'b0;
        data_i     = d;
        data_mod_i = m;
        data_val_i = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk_i);
            done = (data_rdy_o === 1'b1);
            @(posedge clk_i);
            #1;
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL handshake_timeout: word %0h never accepted", d);
        end
        data_val_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        srst_n_i   = 1'b0;
        data_i     = 16'h0000;
        data_mod_i = 4'd0;
        data_val_i = 1'b0;
        cap_clear();
        for (int i = 0; i < NCYC; i++) begin
            ev[i] = 1'b0;
            eb[i] = 1'b0;
        end
        repeat (3) @(posedge clk_i);
        #1;
        srst_n_i = 1'b1;
        @(negedge clk_i);
        chk("reset_val", 64'(ser_data_val_o), 64'd0);
        chk("reset_ser", 64'(ser_data_o), 64'd0);
        chk("reset_busy", 64'(busy_o), 64'd0);
        chk("reset_rdy", 64'(data_rdy_o), 64'd1);
        idle(2);

        // Full-width word from idle
        cap_clear();
        send(16'hA5C3, 4'd0);
        repeat (15) @(posedge clk_i);
        @(negedge clk_i);
        chk("a5c3_val_last", 64'(ser_data_val_o), 64'd1);
        @(posedge clk_i);
        @(negedge clk_i);
        chk("a5c3_val_after", 64'(ser_data_val_o), 64'd0);
        chk("a5c3_busy_after", 64'(busy_o), 64'd0);
        chk("a5c3_count", 64'(cap_n), 64'd16);
        chk("a5c3_bits", cap_w[15:0], 64'h0000_0000_0000_A5C3);
        idle(3);

        // Short word: only the top four bits
        cap_clear();
        send(16'hF000, 4'd4);
        idle(8);
        chk("f000_count", 64'(cap_n), 64'd4);
        chk("f000_bits", 64'(cap_w[3:0]), 64'hF);

        // Illegal lengths are swallowed
        cap_clear();
        send(16'hFFFF, 4'd1);
        send(16'hFFFF, 4'd2);
        idle(5);
        chk("illegal_count", 64'(cap_n), 64'd0);
        chk("illegal_busy", 64'(busy_seen), 64'd0);

        // Continuous stream through the hold buffer
        cap_clear();
        send(16'h8001, 4'd0);
        send(16'h7FFE, 4'd0);
        send(16'hFFFF, 4'd0);
        idle(60);
        chk("stream_count", 64'(cap_n), 64'd48);
        chk("stream_run", 64'(cap_maxrun), 64'd48);
        chk("stream_bits", {16'h0000, cap_w[47:0]}, 64'h0000_8001_7FFE_FFFF);
        chk("stream_rdy_low", 64'(rdy_low_seen), 64'd1);

        // Minimum legal length back to back
        cap_clear();
        send(16'hE000, 4'd3);
        send(16'h4000, 4'd3);
        idle(10);
        chk("len3_count", 64'(cap_n), 64'd6);
        chk("len3_run", 64'(cap_maxrun), 64'd6);
        chk("len3_bits", 64'(cap_w[5:0]), 64'h3A);

        // Illegal word while busy with hold empty is dropped
        cap_clear();
        send(16'h0F0F, 4'd8);
        send(16'hFFFF, 4'd1);
        idle(15);
        chk("drop_count", 64'(cap_n), 64'd8);
        chk("drop_bits", 64'(cap_w[7:0]), 64'h0F);

        // Reset in the middle of a word with hold full
        send(16'h1234, 4'd0);
        send(16'hABCD, 4'd0);
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        chk("midrst_rdy_before", 64'(data_rdy_o), 64'd0);
        chk("midrst_busy_before", 64'(busy_o), 64'd1);
        @(posedge clk_i);
        #1;
        srst_n_i = 1'b0;
        @(posedge clk_i);
        #1;
        srst_n_i = 1'b1;
        @(negedge clk_i);
        chk("midrst_val", 64'(ser_data_val_o), 64'd0);
        chk("midrst_busy", 64'(busy_o), 64'd0);
        chk("midrst_rdy", 64'(data_rdy_o), 64'd1);
        chk("midrst_ser", 64'(ser_data_o), 64'd0);
        cap_clear();
        idle(1);
        send(16'hC0DE, 4'd0);
        idle(40);
        chk("after_rst_count", 64'(cap_n), 64'd16);
        chk("after_rst_bits", cap_w[15:0], 64'h0000_0000_0000_C0DE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
